adc_scan_sequencer: RTL and testbench



---
 rtl/adc_scan_sequencer.sv | 156 +++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
// Scan scheduler: walks the channel mask on each period tick and runs the ADC handshake; ADC_SCAN_AVG_EN averages 4 samples per channel.
// Latency: tick -> conv_start in 2 cycles, conv_done -> result_valid in 1 cycle, last conv_done -> scan_done in 2 cycles.
// Backpressure: holds conv_ch/ISSUE while conv_busy is high, with no timeout.
module adc_scan_sequencer #(
    parameter int NCH = 4,
    parameter int DW  = 12,
    parameter int PW  = 16,
    localparam int CW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic [NCH-1:0] ch_mask,
    input  logic [PW-1:0]  period,
    input  logic [DW-1:0]  threshold,
    output logic           conv_start,
    output logic [CW-1:0]  conv_ch,
    input  logic           conv_busy,
    input  logic           conv_done,
    input  logic [DW-1:0]  conv_data,
    output logic           result_valid,
    output logic [CW-1:0]  result_ch,
    output logic [DW-1:0]  result_data,
    output logic [NCH-1:0] above,
    output logic           scan_done,
    output logic           overrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_TICK, S_PICK, S_ISSUE, S_WAIT_DONE, S_STORE, S_DRAIN
    } state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  cnt;
    logic [NCH-1:0] scan_mask;
    logic [NCH-1:0] ch_onehot;
    logic [CW-1:0]  pick_ch;
    logic           cnt_run;
    logic           tick;
    logic           last_smp;
    logic [DW-1:0]  smp_val;

    // The period counter keeps running through a scan so tick spacing never drifts.
    assign cnt_run   = (state != S_IDLE) && (state != S_DRAIN);
    assign tick      = cnt_run && (cnt == '0);
    assign ch_onehot = NCH'(1) << conv_ch;

`ifdef ADC_SCAN_AVG_EN
    logic [1:0]    smp_cnt;
    logic [DW+1:0] acc;
    logic [DW+1:0] acc_sum;

    assign acc_sum  = acc + {2'b00, conv_data};
    assign last_smp = (smp_cnt == 2'd3);
    assign smp_val  = acc_sum[DW+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_cnt <= '0;
            acc     <= '0;
        end else if (state == S_PICK) begin
            smp_cnt <= '0;
            acc     <= '0;
        end else if (state == S_WAIT_DONE && conv_done && enable) begin
            smp_cnt <= smp_cnt + 2'd1;
            acc     <= acc_sum;
        end
    end
`else
    assign last_smp = 1'b1;
    assign smp_val  = conv_data;
`endif

    always_comb begin
        pick_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (scan_mask[i]) pick_ch = CW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        conv_start = 1'b0;
        scan_done  = 1'b0;
        case (state)
            S_IDLE:      if (enable) state_nxt = S_WAIT_TICK;
            S_WAIT_TICK: begin
                if (!enable)   state_nxt = S_IDLE;
                else if (tick) state_nxt = S_PICK;
            end
            S_PICK: begin
                if (!enable) begin
                    state_nxt = S_IDLE;
                end else if (scan_mask == '0) begin
                    scan_done = 1'b1;
                    state_nxt = S_WAIT_TICK;
                end else begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!enable) begin
                    state_nxt = S_IDLE;
                end else if (!conv_busy) begin
                    conv_start = 1'b1;
                    state_nxt  = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // A conversion already in flight must finish before we may leave.
                if (!enable)        state_nxt = conv_done ? S_IDLE : S_DRAIN;
                else if (conv_done) state_nxt = last_smp ? S_STORE : S_ISSUE;
            end
            S_STORE:     state_nxt = enable ? S_PICK : S_IDLE;
            S_DRAIN:     if (conv_done) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (state == S_IDLE) cnt <= enable ? period : '0;
        else if (cnt_run) cnt <= tick ? period : cnt - PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_mask    <= '0;
            conv_ch      <= '0;
            result_valid <= 1'b0;
            result_ch    <= '0;
            result_data  <= '0;
            above        <= '0;
            overrun      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (state == S_IDLE && !enable) overrun <= 1'b0;
            else if (tick && state != S_WAIT_TICK) overrun <= 1'b1;
            if (state == S_WAIT_TICK && tick && enable) scan_mask <= ch_mask;
            if (state == S_PICK && scan_mask != '0) conv_ch <= pick_ch;
            if (state == S_WAIT_DONE && conv_done && enable && last_smp) begin
                result_valid <= 1'b1;
                result_ch    <= conv_ch;
                result_data  <= smp_val;
                above        <= (above & ~ch_onehot) | ((smp_val > threshold) ? ch_onehot : '0);
                scan_mask    <= scan_mask & ~ch_onehot;
            end
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a latency-programmable ADC model.
module tb_adc_scan_sequencer;
    localparam int NCH = 4;
    localparam int DW  = 12;
    localparam int PW  = 16;
    localparam int CW  = 2;

    logic           clk;
    logic           rst_n;
    logic           enable;
    logic [NCH-1:0] ch_mask;
    logic [PW-1:0]  period;
    logic [DW-1:0]  threshold;
    logic           conv_start;
    logic [CW-1:0]  conv_ch;
    logic           conv_busy;
    logic           conv_done;
    logic [DW-1:0]  conv_data;
    logic           result_valid;
    logic [CW-1:0]  result_ch;
    logic [DW-1:0]  result_data;
    logic [NCH-1:0] above;
    logic           scan_done;
    logic           overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_viol = 0;
    int cyc_ref;

    int            cs_cyc[$];
    logic [CW-1:0] cs_ch[$];
    int            rv_cyc[$];
    logic [DW-1:0] rv_dat[$];
    int            sd_cyc[$];
    int            cd_cyc[$];

    logic [DW-1:0] adc_val [NCH];
    logic [DW-1:0] adc_seq[$];
    int            adc_lat = 3;
    int            pend = 0;
    logic [CW-1:0] pend_ch = '0;

    adc_scan_sequencer #(.NCH(NCH), .DW(DW), .PW(PW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask),
        .period(period), .threshold(threshold), .conv_start(conv_start),
        .conv_ch(conv_ch), .conv_busy(conv_busy), .conv_done(conv_done),
        .conv_data(conv_data), .result_valid(result_valid), .result_ch(result_ch),
        .result_data(result_data), .above(above), .scan_done(scan_done),
        .overrun(overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Event log plus ADC model; runs mid-cycle, away from the active edge.
    initial begin
        conv_done = 1'b0;
        conv_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (conv_start) begin
                cs_cyc.push_back(cyc);
                cs_ch.push_back(conv_ch);
                if (conv_busy) busy_viol++;
            end
            if (result_valid) begin
                rv_cyc.push_back(cyc);
                rv_dat.push_back(result_data);
            end
            if (scan_done) sd_cyc.push_back(cyc);
            conv_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    conv_done = 1'b1;
                    if (adc_seq.size() > 0) conv_data = adc_seq.pop_front();
                    else                    conv_data = adc_val[pend_ch];
                    cd_cyc.push_back(cyc);
                end
            end else if (conv_start) begin
                pend    = adc_lat;
                pend_ch = conv_ch;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int qsz(input int kind);
        case (kind)
            0:       return cs_cyc.size();
            1:       return rv_cyc.size();
            2:       return sd_cyc.size();
            default: return cd_cyc.size();
        endcase
    endfunction

    task automatic wait_for(input string tag, input int kind, input int n, input int budget);
        int k = 0;
        while (qsz(kind) < n && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, 32'(qsz(kind) >= n), 32'd1);
    endtask

    task automatic clear_log();
        cs_cyc.delete();
        cs_ch.delete();
        rv_cyc.delete();
        rv_dat.delete();
        sd_cyc.delete();
        cd_cyc.delete();
    endtask

    function automatic logic [31:0] qi(input int q[$], input int idx);
        return (idx < q.size()) ? 32'(q[idx]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        ch_mask   = '0;
        period    = '0;
        threshold = '0;
        conv_busy = 1'b0;
        adc_val[0] = 12'h900;
        adc_val[1] = 12'h800;
        adc_val[2] = 12'h123;
        adc_val[3] = 12'h7FF;
        step(3);
        chk("reset_conv_start", 32'(conv_start), 32'd0);
        chk("reset_scan_done", 32'(scan_done), 32'd0);
        chk("reset_result", {result_valid, result_ch, result_data}, 32'd0);
        chk("reset_above_overrun", {above, overrun}, 32'd0);
        rst_n = 1'b1;
        step(2);

        // Basic scan over channels 0, 1, 3.
        period    = 16'd99;
        ch_mask   = 4'b1011;
        threshold = 12'h800;
        clear_log();
        cyc_ref = cyc;
        enable  = 1'b1;
        wait_for("basic_scan_done_seen", 2, 1, 300);
        chk("basic_start_count", 32'(cs_cyc.size()), 32'd3);
        chk("basic_ch_seq", {cs_ch.size() == 3 ? {cs_ch[0], cs_ch[1], cs_ch[2]} : 6'h3F}, {2'd0, 2'd1, 2'd3});
        chk("basic_first_start_cyc", qi(cs_cyc, 0), 32'(cyc_ref + 103));
        chk("basic_done_to_valid", qi(rv_cyc, 0) - qi(cd_cyc, 0), 32'd1);
        chk("basic_valid_to_next_start", qi(cs_cyc, 1) - qi(rv_cyc, 0), 32'd2);
        chk("basic_scan_done_cyc", qi(sd_cyc, 0), 32'(cyc_ref + 120));
        chk("basic_last_done_to_scan_done", qi(sd_cyc, 0) - qi(cd_cyc, 2), 32'd2);
        chk("basic_results", {rv_dat.size() == 3 ? {rv_dat[0], rv_dat[1], rv_dat[2]} : 36'hFFF_FFFF_FF}, {12'h900, 12'h800, 12'h7FF});
        chk("basic_last_result", {result_ch, result_data}, {2'd3, 12'h7FF});
        chk("basic_above", 32'(above), 32'b0001);
        wait_for("basic_second_scan_seen", 2, 2, 200);
        chk("basic_tick_spacing", qi(sd_cyc, 1) - qi(sd_cyc, 0), 32'd100);
        chk("basic_no_overrun", 32'(overrun), 32'd0);
        enable = 1'b0;
        step(15);

        // Busy gating: ADC busy well past the tick, then released.
        conv_busy = 1'b1;
        ch_mask   = 4'b0100;
        period    = 16'd5;
        clear_log();
        enable = 1'b1;
        step(30);
        chk("busy_no_start_while_busy", 32'(cs_cyc.size()), 32'd0);
        cyc_ref   = cyc;
        conv_busy = 1'b0;
        wait_for("busy_start_seen", 0, 1, 10);
        chk("busy_start_cyc", qi(cs_cyc, 0), 32'(cyc_ref + 1));
        step(2);
        chk("busy_single_pulse", 32'(cs_cyc.size()), 32'd1);
        chk("busy_start_low", 32'(conv_start), 32'd0);
        chk("busy_overrun_set", 32'(overrun), 32'd1);
        enable = 1'b0;
        step(15);
        chk("busy_overrun_cleared", 32'(overrun), 32'd0);

        // Overrun: short period against a slow ADC.
        period  = 16'd3;
        ch_mask = 4'b0001;
        adc_lat = 10;
        clear_log();
        enable = 1'b1;
        wait_for("ovr_result_seen", 1, 1, 100);
        chk("ovr_set", 32'(overrun), 32'd1);
        step(20);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        enable = 1'b0;
        step(15);
        chk("ovr_cleared_by_disable", 32'(overrun), 32'd0);

        // Disable while a conversion is outstanding.
        period    = 16'd49;
        ch_mask   = 4'b1000;
        adc_val[3] = 12'hFFF;
        clear_log();
        enable = 1'b1;
        wait_for("dis_start_seen", 0, 1, 100);
        enable = 1'b0;
        step(20);
        chk("dis_done_arrived", 32'(cd_cyc.size()), 32'd1);
        chk("dis_no_result_valid", 32'(rv_cyc.size()), 32'd0);
        chk("dis_no_scan_done", 32'(sd_cyc.size()), 32'd0);
        chk("dis_above_kept", 32'(above), 32'b0001);
        step(60);
        chk("dis_idle_no_start", 32'(cs_cyc.size()), 32'd1);

        // Empty mask: scan_done one cycle after every tick.
        period  = 16'd9;
        ch_mask = 4'b0000;
        adc_lat = 3;
        clear_log();
        cyc_ref = cyc;
        enable  = 1'b1;
        wait_for("empty_scans_seen", 2, 3, 60);
        chk("empty_first_scan_done", qi(sd_cyc, 0), 32'(cyc_ref + 12));
        chk("empty_spacing", qi(sd_cyc, 1) - qi(sd_cyc, 0), 32'd10);
        chk("empty_no_start", 32'(cs_cyc.size()), 32'd0);
        enable = 1'b0;
        step(5);

        // Reset while waiting for a conversion.
        period  = 16'd19;
        ch_mask = 4'b0010;
        adc_lat = 10;
        clear_log();
        enable = 1'b1;
        wait_for("rst_start_seen", 0, 1, 60);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", {conv_start, scan_done, result_valid, overrun}, 32'd0);
        chk("rst_mid_ch", {conv_ch, result_ch}, 32'd0);
        chk("rst_mid_data", {above, result_data}, 32'd0);
        enable = 1'b0;
        step(1);
        rst_n = 1'b1;
        clear_log();
        step(40);
        chk("rst_after_no_start", 32'(cs_cyc.size()), 32'd0);
        chk("rst_after_no_result", 32'(rv_cyc.size()), 32'd0);

`ifdef ADC_SCAN_AVG_EN
        // Four samples on channel 2: (10+11+12+14)>>2 = 11.
        adc_lat   = 3;
        period    = 16'd199;
        ch_mask   = 4'b0100;
        threshold = 12'd10;
        adc_seq   = '{12'd10, 12'd11, 12'd12, 12'd14};
        clear_log();
        enable = 1'b1;
        wait_for("avg_result_seen", 1, 1, 300);
        step(5);
        chk("avg_start_count", 32'(cs_cyc.size()), 32'd4);
        chk("avg_result_count", 32'(rv_cyc.size()), 32'd1);
        chk("avg_result", {result_ch, result_data}, {2'd2, 12'd11});
        chk("avg_above", 32'(above), 32'b0100);
        enable = 1'b0;
        step(5);
`endif

        chk("start_never_while_busy", 32'(busy_viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
